// File: rtl/log_capture_ctrl.sv
// Logging-RAM sequencer: arm, optional trigger, decimated capture into consecutive
// addresses until full, then single-word readback for the register file.
module log_capture_ctrl #(
  parameter int RAM_WIDTH  = 32,
  parameter int RAM_DEPTH  = 32000,
  parameter int ADDR_WIDTH = 15,
  parameter int NB_DECIM   = 8
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_arm,
  input  logic                  i_abort,
  input  logic                  i_trig_mode,
  input  logic                  i_trigger,
  input  logic [NB_DECIM-1:0]   i_decim,
  input  logic [RAM_WIDTH-1:0]  i_data,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [RAM_WIDTH-1:0]  i_ram_dout,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [RAM_WIDTH-1:0]  o_ram_din,
  output logic [RAM_WIDTH-1:0]  o_rd_data,
  output logic                  o_rd_valid,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DONE    = 3'd3,
    S_READ    = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  state_t                r_state, w_next;
  logic                  r_arm_d, r_rd_d;
  logic [NB_DECIM-1:0]   r_decim, r_dcnt;
  logic [ADDR_WIDTH-1:0] r_wr_addr, r_ram_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [RAM_WIDTH-1:0]  r_ram_din, r_rd_data;
  logic                  r_ram_en, r_ram_we;
  logic                  r_rd_acc, r_rd_valid, r_rd_fresh, r_rd_oor;

  logic w_arm_edge, w_rd_edge, w_strobe, w_last, w_start_arm, w_start_rd, w_rd_in_range;
  logic [RAM_WIDTH-1:0] w_rd_sel;

  assign w_arm_edge    = i_arm & ~r_arm_d;
  assign w_rd_edge     = i_rd_req & ~r_rd_d;
  assign w_strobe      = (r_state == S_CAPTURE) && (r_dcnt == '0) && !i_abort;
  assign w_last        = w_strobe && (r_wr_addr == LAST_ADDR);
  assign w_start_arm   = !i_abort && w_arm_edge && ((r_state == S_IDLE) || (r_state == S_DONE));
  // An arm edge in DONE wins over a simultaneous read edge.
  assign w_start_rd    = !i_abort && (r_state == S_DONE) && w_rd_edge && !w_arm_edge;
  assign w_rd_in_range = {1'b0, i_rd_addr} < DEPTH_W;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_arm_edge) w_next = S_ARMED;
        S_ARMED:   if (!i_trig_mode || i_trigger) w_next = S_CAPTURE;
        S_CAPTURE: if (w_last) w_next = S_DONE;
        S_DONE: begin
          if (w_arm_edge)     w_next = S_ARMED;
          else if (w_rd_edge) w_next = S_READ;
        end
        S_READ:    if (r_rd_valid && !i_rd_req) w_next = S_DONE;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_state = r_state;
    case (r_state)
      S_ARMED, S_CAPTURE: o_busy = 1'b1;
      S_DONE, S_READ:     o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_arm_d    <= 1'b0;
      r_rd_d     <= 1'b0;
      r_decim    <= '0;
      r_dcnt     <= '0;
      r_wr_addr  <= '0;
      r_count    <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_rd_acc   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_fresh <= 1'b0;
      r_rd_oor   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_arm_d  <= i_arm;
      r_rd_d   <= i_rd_req;
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;

      if (w_start_arm) begin
        r_count   <= '0;
        r_wr_addr <= '0;
        r_decim   <= i_decim;
        r_dcnt    <= '0;
      end

      if ((r_state == S_CAPTURE) && !i_abort) begin
        if (r_dcnt == '0) r_dcnt <= r_decim;
        else              r_dcnt <= r_dcnt - NB_DECIM'(1);
      end

      if (w_strobe) begin
        r_ram_en   <= 1'b1;
        r_ram_we   <= 1'b1;
        r_ram_addr <= r_wr_addr;
        r_ram_din  <= i_data;
        r_wr_addr  <= r_wr_addr + ADDR_WIDTH'(1);
        r_count    <= r_count + (ADDR_WIDTH + 1)'(1);
      end

      // Out-of-range reads skip the RAM but still complete with zero data.
      if (w_start_rd) begin
        r_rd_oor <= !w_rd_in_range;
        if (w_rd_in_range) begin
          r_ram_en   <= 1'b1;
          r_ram_addr <= i_rd_addr;
        end
      end

      r_rd_acc <= w_start_rd;
      if (i_abort) begin
        r_rd_valid <= 1'b0;
        r_rd_fresh <= 1'b0;
      end else if (r_rd_acc) begin
        r_rd_valid <= 1'b1;
        r_rd_fresh <= 1'b1;
      end else begin
        r_rd_fresh <= 1'b0;
        if ((r_state == S_READ) && r_rd_valid && !i_rd_req) r_rd_valid <= 1'b0;
      end

      if (r_rd_fresh) r_rd_data <= w_rd_sel;
    end
  end

  // RAM data passes straight through on the first valid cycle, then the captured copy is held.
  assign w_rd_sel   = r_rd_oor ? '0 : i_ram_dout;
  assign o_rd_data  = r_rd_fresh ? w_rd_sel : r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_ram_en   = r_ram_en;
  assign o_ram_we   = r_ram_we;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_din  = r_ram_din;
  assign o_count    = r_count;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Scoreboard bench for log_capture_ctrl: a schedule-based model predicts RAM writes and reads.
module tb_log_capture_ctrl;
  localparam int RW = 32;
  localparam int RD = 8;
  localparam int AW = 4;
  localparam int ND = 8;

  logic          clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_arm = 1'b0, i_abort = 1'b0, i_trig_mode = 1'b0, i_trigger = 1'b0;
  logic [ND-1:0] i_decim = '0;
  logic [RW-1:0] i_data = '0;
  logic          i_rd_req = 1'b0;
  logic [AW-1:0] i_rd_addr = '0;
  logic [RW-1:0] i_ram_dout = '0;
  logic          o_ram_en, o_ram_we, o_rd_valid, o_busy, o_done;
  logic [AW-1:0] o_ram_addr;
  logic [RW-1:0] o_ram_din, o_rd_data;
  logic [AW:0]   o_count;
  logic [2:0]    o_state;

  log_capture_ctrl #(.RAM_WIDTH(RW), .RAM_DEPTH(RD), .ADDR_WIDTH(AW), .NB_DECIM(ND)) dut (
    .clock(clock), .i_reset(i_reset), .i_arm(i_arm), .i_abort(i_abort),
    .i_trig_mode(i_trig_mode), .i_trigger(i_trigger), .i_decim(i_decim), .i_data(i_data),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_ram_dout(i_ram_dout),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_count(o_count),
    .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [RW-1:0] ram [16];
  always @(posedge clock) begin
    if (o_ram_en) begin
      if (o_ram_we) ram[o_ram_addr] <= o_ram_din;
      else          i_ram_dout <= ram[o_ram_addr];
    end
  end

  typedef struct {
    int            cyc;
    bit            is_rd;
    int            addr;
    logic [RW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [RW-1:0] exp_mem [RD];
  int  m_next = -1, m_left = 0, m_step = 1, m_addr = 0;
  bit  use_cyc = 1'b1;
  int  n_checks = 0, n_err = 0;
  int  first_wr = -1, last_wr = -1;
  bit  prev_valid = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sample source + model: capture writes one sample every m_step cycles from m_next on.
  initial begin
    forever begin
      exp_t e;
      @(posedge clock);
      #2;
      i_data = use_cyc ? RW'(cyc) : RW'($urandom);
      if (m_left > 0 && cyc == m_next) begin
        e.cyc = cyc + 1; e.is_rd = 1'b0; e.addr = m_addr; e.data = i_data;
        exp_q.push_back(e);
        exp_mem[m_addr] = i_data;
        m_addr++; m_left--; m_next += m_step;
      end
    end
  end

  always @(negedge clock) begin : monitor
    exp_t e;
    if (i_reset) begin
      if (o_ram_we) begin
        if (exp_q.size() == 0 || exp_q[0].is_rd) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_write: addr %0d data %0h at cycle %0d, no write required", o_ram_addr, o_ram_din, cyc);
        end else begin
          e = exp_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", longint'(o_ram_addr), e.addr);
          check("wr_data", longint'(o_ram_din), longint'(e.data));
          if (first_wr < 0) first_wr = cyc;
          last_wr = cyc;
        end
      end
      if (o_rd_valid && !prev_valid) begin
        if (exp_q.size() == 0 || !exp_q[0].is_rd) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_read: data %0h at cycle %0d, no read required", o_rd_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("rd_cycle", cyc, e.cyc);
          check("rd_data", longint'(o_rd_data), longint'(e.data));
        end
      end
    end
    prev_valid = o_rd_valid;
  end

  task automatic arm_only(input bit tmode, input int d, output int t);
    i_trig_mode = tmode; i_decim = ND'(d); i_arm = 1'b1; t = cyc;
    m_step = d + 1; m_addr = 0; m_left = RD; m_next = tmode ? -1 : t + 2;
    first_wr = -1; last_wr = -1;
    tick();
    i_arm = 1'b0; i_rd_req = 1'b0;
    check("armed_state", longint'(o_state), 1);
    check("armed_count", longint'(o_count), 0);
  endtask

  task automatic run(input bit tmode, input int d, input int tdelay, input bit poke, input int abort_after);
    int t, first, exp_done, n_armed, g, nw;
    arm_only(tmode, d, t);
    if (tmode) begin
      n_armed = 0;
      while (cyc < t + tdelay) begin
        if (o_state == 3'd1) n_armed++;
        tick();
      end
      if (o_state == 3'd1) n_armed++;
      i_trigger = 1'b1; m_next = cyc + 1; first = cyc + 1;
      tick();
      i_trigger = 1'b0;
      check("armed_cycles", n_armed, tdelay);
    end else begin
      first = t + 2;
    end
    if (abort_after > 0) begin
      while (cyc < first + abort_after) tick();
      i_abort = 1'b1; m_left = 0;
      tick();
      i_abort = 1'b0;
      nw = (abort_after + d) / (d + 1);
      check("abort_state", longint'(o_state), 0);
      check("abort_count", longint'(o_count), nw);
      check("abort_we", longint'(o_ram_we), 0);
      check("abort_rd_valid", longint'(o_rd_valid), 0);
      repeat (2 * (d + 1) + 2) tick();
      check("abort_hold_count", longint'(o_count), nw);
      return;
    end
    exp_done = first + (RD - 1) * (d + 1) + 1;
    g = 0;
    while (!o_done && g < 500) begin
      if (poke) i_arm = (cyc == first + 3);
      tick();
      g++;
    end
    i_arm = 1'b0;
    check("done_cycle", cyc, exp_done);
    check("done_count", longint'(o_count), RD);
    check("done_state", longint'(o_state), 3);
    check("done_busy", longint'(o_busy), 0);
    tick();
    check("strobe_span", last_wr - first_wr, (RD - 1) * (d + 1));
  endtask

  task automatic rd(input int a);
    exp_t e;
    int   r;
    i_rd_addr = AW'(a); i_rd_req = 1'b1; r = cyc;
    e.cyc = r + 2; e.is_rd = 1'b1; e.addr = a;
    e.data = (a < RD) ? exp_mem[a] : '0;
    exp_q.push_back(e);
    tick();
    check("rd_state", longint'(o_state), 4);
    check("rd_ram_en", longint'(o_ram_en), (a < RD) ? 1 : 0);
    check("rd_ram_we", longint'(o_ram_we), 0);
    if (a < RD) check("rd_ram_addr", longint'(o_ram_addr), a);
    repeat (3) tick();
    check("rd_hold_valid", longint'(o_rd_valid), 1);
    i_rd_req = 1'b0;
    tick();
    check("rd_back_state", longint'(o_state), 3);
    check("rd_valid_clear", longint'(o_rd_valid), 0);
    check("rd_data_held", longint'(o_rd_data), longint'(e.data));
  endtask

  initial begin
    int t;
    repeat (3) tick();
    check("rst_state", longint'(o_state), 0);
    check("rst_flags", longint'({o_busy, o_done, o_ram_en, o_ram_we, o_rd_valid}), 0);
    check("rst_count", longint'(o_count), 0);
    check("rst_bus", longint'(o_ram_addr) + longint'(o_ram_din) + longint'(o_rd_data), 0);
    i_reset = 1'b1;
    tick();

    // Reset in the middle of a capture, after three writes have landed.
    arm_only(1'b0, 0, t);
    while (cyc < t + 5) tick();
    @(negedge clock);
    #1;
    check("pre_reset_writes", last_wr - first_wr, 2);
    i_reset = 1'b0; exp_q.delete(); m_left = 0;
    #1;
    check("async_rst_state", longint'(o_state), 0);
    check("async_rst_flags", longint'({o_busy, o_done, o_ram_en, o_ram_we, o_rd_valid}), 0);
    check("async_rst_count", longint'(o_count), 0);
    check("async_rst_bus", longint'(o_ram_addr) + longint'(o_ram_din), 0);
    tick();
    i_reset = 1'b1;
    tick();

    run(1'b0, 0, 0, 1'b0, 0);
    rd(5); rd(0); rd(9);

    run(1'b1, 2, 10, 1'b0, 0);
    rd(7); rd(3);

    run(1'b0, 0, 0, 1'b0, 4);
    run(1'b0, 0, 0, 1'b0, 0);

    // Abort together with an arm edge.
    i_arm = 1'b1; i_abort = 1'b1;
    tick();
    i_arm = 1'b0; i_abort = 1'b0;
    check("abort_arm_state", longint'(o_state), 0);
    tick();

    // Read request while idle is ignored.
    i_rd_addr = AW'(2); i_rd_req = 1'b1;
    repeat (3) tick();
    check("idle_rd_valid", longint'(o_rd_valid), 0);
    check("idle_rd_en", longint'(o_ram_en), 0);
    i_rd_req = 1'b0;
    tick();

    run(1'b0, 0, 0, 1'b1, 0);

    // Arm and read edges together in DONE: arm wins.
    i_rd_addr = AW'(1); i_rd_req = 1'b1;
    run(1'b0, 1, 0, 1'b0, 0);
    rd(1);

    use_cyc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      run(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 1'b0, 0);
      for (int j = 0; j < 3; j++) rd(int'($urandom_range(0, 11)));
    end

    repeat (3) tick();
    check("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
